// File: rtl/crossbar_2x2.sv
// 2-master / 2-slave bus crossbar.
// Address MSB selects the slave. Each slave has an arbiter that is IDLE or BUSY(owner).
// A read handshake returns its data to the originating master one cycle later.
// Build option: define CROSSBAR_RR_ARB_EN for per-slave round-robin arbitration.
// Without it, conflicts use fixed priority and master 0 always wins.
module crossbar_2x2 #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              master_0_req,
    input  logic              master_0_cmd,
    input  logic [ADDR_W-1:0] master_0_addr,
    input  logic [DATA_W-1:0] master_0_wdata,
    output logic              master_0_ack,
    output logic [DATA_W-1:0] master_0_rdata,
    input  logic              master_1_req,
    input  logic              master_1_cmd,
    input  logic [ADDR_W-1:0] master_1_addr,
    input  logic [DATA_W-1:0] master_1_wdata,
    output logic              master_1_ack,
    output logic [DATA_W-1:0] master_1_rdata,
    output logic              slave_0_req,
    output logic              slave_0_cmd,
    output logic [ADDR_W-1:0] slave_0_addr,
    output logic [DATA_W-1:0] slave_0_wdata,
    input  logic              slave_0_ack,
    input  logic [DATA_W-1:0] slave_0_rdata,
    output logic              slave_1_req,
    output logic              slave_1_cmd,
    output logic [ADDR_W-1:0] slave_1_addr,
    output logic [DATA_W-1:0] slave_1_wdata,
    input  logic              slave_1_ack,
    input  logic [DATA_W-1:0] slave_1_rdata
);

    // Master-side inputs gathered into indexable form
    logic [1:0]        m_req;
    logic [1:0]        m_cmd;
    logic [1:0]        m_tgt;
    logic [ADDR_W-1:0] m_addr  [2];
    logic [DATA_W-1:0] m_wdata [2];
    logic [1:0]        s_ack;
    logic [DATA_W-1:0] s_rdata [2];

    // Per-slave grant / response status, and per-port outputs
    logic [1:0]        gnt_vld;
    logic [1:0]        gnt_id;
    logic [1:0]        rsp_vld;
    logic [1:0]        rsp_owner;
    logic [1:0]        s_req;
    logic [1:0]        s_cmd;
    logic [ADDR_W-1:0] s_addr  [2];
    logic [DATA_W-1:0] s_wdata [2];
    logic [1:0]        m_ack;
    logic [DATA_W-1:0] m_rdata [2];

    assign m_req      = {master_1_req, master_0_req};
    assign m_cmd      = {master_1_cmd, master_0_cmd};
    assign m_tgt      = {master_1_addr[ADDR_W-1], master_0_addr[ADDR_W-1]};
    assign m_addr[0]  = master_0_addr;
    assign m_addr[1]  = master_1_addr;
    assign m_wdata[0] = master_0_wdata;
    assign m_wdata[1] = master_1_wdata;
    assign s_ack      = {slave_1_ack, slave_0_ack};
    assign s_rdata[0] = slave_0_rdata;
    assign s_rdata[1] = slave_1_rdata;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slave
            localparam logic SEL = (gi == 1);

            logic [1:0] req_vec;
            logic       prio_id;
            logic       busy_reg;
            logic       owner_reg;
            logic       rsp_vld_reg;
            logic       rsp_owner_reg;
            logic       grant_vld;
            logic       grant_id;
            logic       handshake;

            // Masters currently addressing this slave
            assign req_vec = m_req & {m_tgt[1] == SEL, m_tgt[0] == SEL};

`ifdef CROSSBAR_RR_ARB_EN
            logic rr_ptr_reg;

            // After each ack the master that was not served gets priority
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    rr_ptr_reg <= 1'b0;
                end else if (handshake) begin
                    rr_ptr_reg <= ~grant_id;
                end
            end

            assign prio_id = rr_ptr_reg;
`else
            assign prio_id = 1'b0;
`endif

            // Grant: locked to the owner while stalled, otherwise lone requester or priority winner
            always_comb begin
                grant_vld = 1'b0;
                grant_id  = 1'b0;
                if (busy_reg) begin
                    grant_vld = req_vec[owner_reg];
                    grant_id  = owner_reg;
                end else begin
                    case (req_vec)
                        2'b01: begin
                            grant_vld = 1'b1;
                            grant_id  = 1'b0;
                        end
                        2'b10: begin
                            grant_vld = 1'b1;
                            grant_id  = 1'b1;
                        end
                        2'b11: begin
                            grant_vld = 1'b1;
                            grant_id  = prio_id;
                        end
                        default: begin
                            grant_vld = 1'b0;
                            grant_id  = 1'b0;
                        end
                    endcase
                end
            end

            assign handshake = grant_vld & s_ack[gi];

            // Arbiter lock (stalled grant) and read-return bookkeeping
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    busy_reg      <= 1'b0;
                    owner_reg     <= 1'b0;
                    rsp_vld_reg   <= 1'b0;
                    rsp_owner_reg <= 1'b0;
                end else begin
                    // An owner that drops its request also releases the lock
                    busy_reg <= grant_vld & ~s_ack[gi];
                    if (grant_vld) begin
                        owner_reg <= grant_id;
                    end
                    rsp_vld_reg   <= handshake & ~m_cmd[grant_id];
                    rsp_owner_reg <= grant_id;
                end
            end

            // Every combinational output is forced low while reset is asserted
            assign gnt_vld[gi]   = grant_vld & reset;
            assign gnt_id[gi]    = grant_id;
            assign rsp_vld[gi]   = rsp_vld_reg & reset;
            assign rsp_owner[gi] = rsp_owner_reg;
            assign s_req[gi]     = gnt_vld[gi];
            assign s_cmd[gi]     = gnt_vld[gi] & m_cmd[grant_id];
            assign s_addr[gi]    = gnt_vld[gi] ? m_addr[grant_id]  : '0;
            assign s_wdata[gi]   = gnt_vld[gi] ? m_wdata[grant_id] : '0;
        end

        for (genvar gi = 0; gi < 2; gi++) begin : g_master
            localparam logic ID = (gi == 1);

            logic [DATA_W-1:0] rdata;

            assign m_ack[gi] = (gnt_vld[0] & (gnt_id[0] == ID) & s_ack[0]) |
                               (gnt_vld[1] & (gnt_id[1] == ID) & s_ack[1]);

            // Route returning read data from whichever slave owes this master a response
            always_comb begin
                rdata = '0;
                for (int m = 0; m < 2; m++) begin
                    if (rsp_vld[m] && (rsp_owner[m] == ID)) begin
                        rdata = rdata | s_rdata[m];
                    end
                end
            end

            assign m_rdata[gi] = rdata;
        end
    endgenerate

    assign master_0_ack   = m_ack[0];
    assign master_1_ack   = m_ack[1];
    assign master_0_rdata = m_rdata[0];
    assign master_1_rdata = m_rdata[1];
    assign slave_0_req    = s_req[0];
    assign slave_0_cmd    = s_cmd[0];
    assign slave_0_addr   = s_addr[0];
    assign slave_0_wdata  = s_wdata[0];
    assign slave_1_req    = s_req[1];
    assign slave_1_cmd    = s_cmd[1];
    assign slave_1_addr   = s_addr[1];
    assign slave_1_wdata  = s_wdata[1];

endmodule

// File: tb/tb_crossbar_2x2.sv
// Self-checking bench for crossbar_2x2: one task per scenario, read returns via scoreboard queue.
module tb_crossbar_2x2;

    logic        clock = 1'b0;
    logic        reset;
    logic        m0_req, m0_cmd, m1_req, m1_cmd;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ack, m1_ack;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s0_req, s0_cmd, s1_req, s1_cmd;
    logic [31:0] s0_addr, s0_wdata, s1_addr, s1_wdata;
    logic        s0_ack, s1_ack;
    logic [31:0] s0_rdata, s1_rdata;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int          mst;
        logic [31:0] data;
    } rsp_t;
    rsp_t exp_q[$];

    always #5 clock = ~clock;

    crossbar_2x2 #(.ADDR_W(32), .DATA_W(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .master_0_req   (m0_req),
        .master_0_cmd   (m0_cmd),
        .master_0_addr  (m0_addr),
        .master_0_wdata (m0_wdata),
        .master_0_ack   (m0_ack),
        .master_0_rdata (m0_rdata),
        .master_1_req   (m1_req),
        .master_1_cmd   (m1_cmd),
        .master_1_addr  (m1_addr),
        .master_1_wdata (m1_wdata),
        .master_1_ack   (m1_ack),
        .master_1_rdata (m1_rdata),
        .slave_0_req    (s0_req),
        .slave_0_cmd    (s0_cmd),
        .slave_0_addr   (s0_addr),
        .slave_0_wdata  (s0_wdata),
        .slave_0_ack    (s0_ack),
        .slave_0_rdata  (s0_rdata),
        .slave_1_req    (s1_req),
        .slave_1_cmd    (s1_cmd),
        .slave_1_addr   (s1_addr),
        .slave_1_wdata  (s1_wdata),
        .slave_1_ack    (s1_ack),
        .slave_1_rdata  (s1_rdata)
    );

    function automatic logic [197:0] all_outs();
        return {m0_ack, m1_ack, m0_rdata, m1_rdata,
                s0_req, s0_cmd, s0_addr, s0_wdata,
                s1_req, s1_cmd, s1_addr, s1_wdata};
    endfunction

    task automatic clear_inputs();
        m0_req = 1'b0; m0_cmd = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_cmd = 1'b0; m1_addr = '0; m1_wdata = '0;
        s0_ack = 1'b0; s0_rdata = '0;
        s1_ack = 1'b0; s1_rdata = '0;
    endtask

    task automatic set_master(input int n, input logic req, input logic cmd,
                              input logic [31:0] addr, input logic [31:0] wdata);
        if (n == 0) begin
            m0_req = req; m0_cmd = cmd; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = req; m1_cmd = cmd; m1_addr = addr; m1_wdata = wdata;
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_inputs();
        next_cycle();
        next_cycle();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [197:0] outs;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            m0_req = 1'($urandom); m0_cmd = 1'($urandom); m0_addr = $urandom; m0_wdata = $urandom;
            m1_req = 1'($urandom); m1_cmd = 1'($urandom); m1_addr = $urandom; m1_wdata = $urandom;
            s0_ack = 1'($urandom); s0_rdata = $urandom;
            s1_ack = 1'($urandom); s1_rdata = $urandom;
            @(negedge clock);
            outs = all_outs();
            n_cmp++;
            if (outs !== '0) begin
                n_err++;
                $display("FAIL reset_outputs[%0d]: got %h, want 0", i, outs);
            end else begin
                $display("ok   reset_outputs[%0d]", i);
            end
        end
        next_cycle();
        clear_inputs();
        reset = 1'b1;
        @(negedge clock);
        outs = all_outs();
        n_cmp++;
        if (outs !== '0) begin
            n_err++;
            $display("FAIL reset_idle: got %h, want 0", outs);
        end else begin
            $display("ok   reset_idle");
        end
    endtask

    task automatic test_parallel();
        rsp_t        r;
        logic [31:0] got_own, got_oth;
        next_cycle();
        set_master(0, 1'b1, 1'b1, 32'h0000_0010, 32'hA5A5_A5A5);
        set_master(1, 1'b1, 1'b0, 32'h8000_0020, 32'h0000_0000);
        s0_ack = 1'b1;
        s1_ack = 1'b1;
        @(negedge clock);
        n_cmp++;
        if ({s0_req, s0_cmd, s0_addr, s0_wdata} !== {1'b1, 1'b1, 32'h0000_0010, 32'hA5A5_A5A5}) begin
            n_err++;
            $display("FAIL par_s0: got req=%b cmd=%b addr=%h wdata=%h, want 1 1 00000010 a5a5a5a5",
                     s0_req, s0_cmd, s0_addr, s0_wdata);
        end else $display("ok   par_s0 write forwarded");
        n_cmp++;
        if ({s1_req, s1_cmd, s1_addr, s1_wdata} !== {1'b1, 1'b0, 32'h8000_0020, 32'h0}) begin
            n_err++;
            $display("FAIL par_s1: got req=%b cmd=%b addr=%h wdata=%h, want 1 0 80000020 00000000",
                     s1_req, s1_cmd, s1_addr, s1_wdata);
        end else $display("ok   par_s1 read forwarded");
        n_cmp++;
        if ({m0_ack, m1_ack} !== 2'b11) begin
            n_err++;
            $display("FAIL par_acks: got %b%b, want 11", m0_ack, m1_ack);
        end else $display("ok   par_acks");
        exp_q.push_back('{1, 32'h1234_5678});
        next_cycle();
        clear_inputs();
        s1_rdata = 32'h1234_5678;
        @(negedge clock);
        if (exp_q.size() != 0) begin
            r = exp_q.pop_front();
            got_own = (r.mst == 0) ? m0_rdata : m1_rdata;
            got_oth = (r.mst == 0) ? m1_rdata : m0_rdata;
            n_cmp++;
            if (got_own !== r.data || got_oth !== 32'h0) begin
                n_err++;
                $display("FAIL par_rdata: m%0d got %h other %h, want %h other 0",
                         r.mst, got_own, got_oth, r.data);
            end else $display("ok   par_rdata m%0d = %h", r.mst, got_own);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_conflict();
        int          win;
        logic [65:0] got, want;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_master(0, (i < 4), 1'b1, 32'h8000_0100, 32'hAAAA_0000);
            set_master(1, 1'b1, 1'b1, 32'h8000_0200, 32'hBBBB_0000);
            s1_ack = 1'b1;
`ifdef CROSSBAR_RR_ARB_EN
            win = (i == 4) ? 1 : (i % 2);
`else
            win = (i == 4) ? 1 : 0;
`endif
            @(negedge clock);
            got  = {m0_ack, m1_ack, s1_addr, s1_wdata};
            want = {(win == 0), (win == 1),
                    (win == 0) ? 32'h8000_0100 : 32'h8000_0200,
                    (win == 0) ? 32'hAAAA_0000 : 32'hBBBB_0000};
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL conflict[%0d]: got %h, want %h (winner m%0d)", i, got, want, win);
            end else $display("ok   conflict[%0d] granted m%0d", i, win);
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_stall_lock();
        int          oth, gnt;
        logic [66:0] got, want;
        for (int own = 0; own < 2; own++) begin
            oth = 1 - own;
            do_reset();
            set_master(own, 1'b1, 1'b1, 32'h0000_0040, 32'hC0C0_C0C0);
            for (int c = 0; c < 7; c++) begin
                if (c == 3) set_master(oth, 1'b1, 1'b1, 32'h0000_0050, 32'hD0D0_D0D0);
                if (c == 6) set_master(own, 1'b0, 1'b0, 32'h0, 32'h0);
                s0_ack = (c >= 5);
                gnt = (c == 6) ? oth : own;
                @(negedge clock);
                got  = {s0_req, s0_addr, s0_wdata, m0_ack, m1_ack};
                want = {1'b1,
                        (gnt == own) ? 32'h0000_0040 : 32'h0000_0050,
                        (gnt == own) ? 32'hC0C0_C0C0 : 32'hD0D0_D0D0,
                        (c >= 5) && (gnt == 0), (c >= 5) && (gnt == 1)};
                n_cmp++;
                if (got !== want) begin
                    n_err++;
                    $display("FAIL stall_own%0d[%0d]: got %h, want %h", own, c, got, want);
                end else $display("ok   stall_own%0d[%0d] slave0 on m%0d", own, c, gnt);
                next_cycle();
            end
            clear_inputs();
        end
    endtask

    task automatic test_back_to_back();
        rsp_t        r;
        logic [31:0] got_own, got_oth;
        next_cycle();
        for (int c = 0; c < 4; c++) begin
            clear_inputs();
            if (c == 0) begin
                set_master(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
                s0_ack = 1'b1;
            end
            if (c == 1) begin
                set_master(0, 1'b1, 1'b0, 32'h8000_0100, 32'h0);
                s1_ack   = 1'b1;
                s0_rdata = 32'h0000_0011;
            end
            if (c == 2) s1_rdata = 32'h0000_0022;
            if (c == 3) s1_rdata = 32'h0000_0033;
            @(negedge clock);
            if (c < 2) begin
                n_cmp++;
                if ({m0_ack, m1_ack} !== 2'b10) begin
                    n_err++;
                    $display("FAIL b2b_ack[%0d]: got %b%b, want 10", c, m0_ack, m1_ack);
                end else $display("ok   b2b_ack[%0d]", c);
            end
            if (c >= 1 && exp_q.size() != 0) begin
                r = exp_q.pop_front();
                got_own = (r.mst == 0) ? m0_rdata : m1_rdata;
                got_oth = (r.mst == 0) ? m1_rdata : m0_rdata;
                n_cmp++;
                if (got_own !== r.data || got_oth !== 32'h0) begin
                    n_err++;
                    $display("FAIL b2b_rdata[%0d]: m%0d got %h other %h, want %h other 0",
                             c, r.mst, got_own, got_oth, r.data);
                end else $display("ok   b2b_rdata[%0d] m%0d = %h", c, r.mst, got_own);
            end
            if (c == 3) begin
                n_cmp++;
                if ({m0_rdata, m1_rdata} !== 64'h0) begin
                    n_err++;
                    $display("FAIL b2b_idle_rdata: got %h %h, want 0 0", m0_rdata, m1_rdata);
                end else $display("ok   b2b_idle_rdata");
            end
            if (c == 0) exp_q.push_back('{0, 32'h0000_0011});
            if (c == 1) exp_q.push_back('{0, 32'h0000_0022});
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_mid_reset();
        logic [197:0] outs;
        do_reset();
        set_master(1, 1'b1, 1'b0, 32'h8000_0040, 32'h0);
        next_cycle();
        next_cycle();
        @(negedge clock);
        n_cmp++;
        if ({s1_req, s1_addr, m1_ack} !== {1'b1, 32'h8000_0040, 1'b0}) begin
            n_err++;
            $display("FAIL midrst_stalled: got req=%b addr=%h ack=%b, want 1 80000040 0",
                     s1_req, s1_addr, m1_ack);
        end else $display("ok   midrst_stalled");
        #2;
        reset = 1'b0;
        #1;
        outs = all_outs();
        n_cmp++;
        if (outs !== '0) begin
            n_err++;
            $display("FAIL midrst_outputs: got %h, want 0", outs);
        end else $display("ok   midrst_outputs");
        next_cycle();
        clear_inputs();
        s1_rdata = 32'h5555_5555;
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            n_cmp++;
            if ({m0_rdata, m1_rdata, s1_req} !== 65'h0) begin
                n_err++;
                $display("FAIL midrst_no_rdata[%0d]: got %h %h req=%b, want 0 0 0",
                         k, m0_rdata, m1_rdata, s1_req);
            end else $display("ok   midrst_no_rdata[%0d]", k);
            next_cycle();
        end
        set_master(0, 1'b1, 1'b1, 32'h8000_0080, 32'h0000_0077);
        s1_ack = 1'b1;
        @(negedge clock);
        n_cmp++;
        if ({s1_req, s1_addr, m0_ack} !== {1'b1, 32'h8000_0080, 1'b1}) begin
            n_err++;
            $display("FAIL midrst_arb_idle: got req=%b addr=%h ack=%b, want 1 80000080 1",
                     s1_req, s1_addr, m0_ack);
        end else $display("ok   midrst_arb_idle");
        next_cycle();
        clear_inputs();
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        test_reset();
        test_parallel();
        test_conflict();
        test_stall_lock();
        test_back_to_back();
        test_mid_reset();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end else $display("ok   scoreboard_drain");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
